// File: rtl/cam_frame_decimator_if.sv
// Framebuffer write port: valid/ready handshake carrying a 160x120 address and an RGB565 pixel.
interface cam_frame_decimator_if;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ready;

  modport master (output wr_en, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/cam_frame_decimator.sv
// Camera stream 4x4 decimator: averages 4 pixels horizontally on every 4th row and buffers writes
// into a small first-word-fall-through FIFO. Define CAM_MIRROR_EN to flip the image in both axes.
module cam_frame_decimator #(
  parameter int unsigned SRC_W      = 640,
  parameter int unsigned SRC_H      = 480,
  parameter int unsigned DST_W      = 160,
  parameter int unsigned DST_H      = 120,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         frame_start,
  input  logic                         line_end,
  input  logic                         pix_valid,
  input  logic [15:0]                  pix_data,
  input  logic [4:0]                   y_offset,
  cam_frame_decimator_if.master        wr,
  output logic                         frame_done,
  output logic                         overflow
);

  localparam int unsigned XW  = $clog2(SRC_W + 1);
  localparam int unsigned YW  = $clog2(SRC_H + 1);
  localparam int unsigned DXW = $clog2(DST_W);
  localparam int unsigned DYW = $clog2(DST_H + 32);
  localparam int unsigned AW  = 15;
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_entry_t;

  state_t          r_state;
  logic [XW-1:0]   r_src_x;
  logic [YW-1:0]   r_src_y;
  logic [6:0]      r_sum_r;
  logic [7:0]      r_sum_g;
  logic [6:0]      r_sum_b;
  logic            r_fs_pend;
  logic            r_frame_done;
  logic            r_overflow;
  logic            r_push_vld;
  wr_entry_t       r_push;
  wr_entry_t       r_q [FIFO_DEPTH];
  logic [CW-1:0]   r_cnt;
  logic            r_wr_en;

  logic            w_take;
  logic            w_acc;
  logic            w_grp_done;
  logic [6:0]      w_sum_r;
  logic [7:0]      w_sum_g;
  logic [6:0]      w_sum_b;
  logic [DXW-1:0]  w_dx;
  logic [DYW-1:0]  w_dy;
  wr_entry_t       w_entry;
  logic            w_pop;
  logic [CW-1:0]   w_cnt_pop;
  logic            w_fifo_wr;
  logic [PW-1:0]   w_wr_idx;
  logic [CW-1:0]   w_cnt_nxt;

  // Pixel acceptance, group sums and destination address of the group being completed.
  always_comb begin
    w_take     = (r_state == S_ACTIVE) && !frame_start && pix_valid &&
                 (r_src_x < XW'(SRC_W)) && (r_src_y < YW'(SRC_H));
    w_acc      = w_take && (r_src_y[1:0] == 2'd0);
    w_grp_done = w_acc && (r_src_x[1:0] == 2'd3);
    w_sum_r    = r_sum_r + 7'(pix_data[15:11]);
    w_sum_g    = r_sum_g + 8'(pix_data[10:5]);
    w_sum_b    = r_sum_b + 7'(pix_data[4:0]);
    w_dx       = DXW'(r_src_x >> 2);
    w_dy       = DYW'(r_src_y >> 2);
`ifdef CAM_MIRROR_EN
    w_dx       = DXW'(DST_W - 1) - w_dx;
    w_dy       = DYW'(DST_H - 1) - w_dy;
`endif
    w_dy       = w_dy + DYW'(y_offset);
    if (w_dy >= DYW'(DST_H)) begin
      w_dy = w_dy - DYW'(DST_H);
    end
    w_entry.addr = AW'(w_dy) * AW'(DST_W) + AW'(w_dx);
    w_entry.data = {w_sum_r[6:2], w_sum_g[7:2], w_sum_b[6:2]};
  end

  // FIFO bookkeeping: a pop frees a slot for a push in the same cycle even when full.
  always_comb begin
    w_pop     = r_wr_en && wr.wr_ready;
    w_cnt_pop = r_cnt - CW'(w_pop);
    w_fifo_wr = r_push_vld && (w_pop || (r_cnt < CW'(FIFO_DEPTH)));
    w_wr_idx  = PW'(w_cnt_pop);
    w_cnt_nxt = w_cnt_pop + CW'(w_fifo_wr);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_src_x      <= '0;
      r_src_y      <= '0;
      r_sum_r      <= '0;
      r_sum_g      <= '0;
      r_sum_b      <= '0;
      r_fs_pend    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (frame_start) begin
            r_state <= S_ACTIVE;
            r_src_x <= '0;
            r_src_y <= '0;
            r_sum_r <= '0;
            r_sum_g <= '0;
            r_sum_b <= '0;
          end
        end
        S_ACTIVE: begin
          if (frame_start) begin
            r_src_x <= '0;
            r_src_y <= '0;
            r_sum_r <= '0;
            r_sum_g <= '0;
            r_sum_b <= '0;
          end else begin
            if (w_take) begin
              r_src_x <= r_src_x + XW'(1);
            end
            if (w_acc) begin
              r_sum_r <= w_grp_done ? 7'd0 : w_sum_r;
              r_sum_g <= w_grp_done ? 8'd0 : w_sum_g;
              r_sum_b <= w_grp_done ? 7'd0 : w_sum_b;
            end
            // Line end lands after the same-cycle pixel, discarding any partial group.
            if (line_end) begin
              r_src_x <= '0;
              r_sum_r <= '0;
              r_sum_g <= '0;
              r_sum_b <= '0;
              r_src_y <= r_src_y + YW'(1);
              if ((r_src_y + YW'(1)) == YW'(SRC_H)) begin
                r_state <= S_DRAIN;
              end
            end
          end
        end
        S_DRAIN: begin
          if (frame_start) begin
            r_fs_pend <= 1'b1;
          end
          if (!r_push_vld && !r_wr_en) begin
            r_frame_done <= 1'b1;
            r_fs_pend    <= 1'b0;
            r_src_x      <= '0;
            r_src_y      <= '0;
            r_sum_r      <= '0;
            r_sum_g      <= '0;
            r_sum_b      <= '0;
            r_state      <= (r_fs_pend || frame_start) ? S_ACTIVE : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // One-entry push stage feeding a shift-register FIFO whose entry 0 is the output head.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_push_vld <= 1'b0;
      r_push     <= '0;
      r_cnt      <= '0;
      r_wr_en    <= 1'b0;
      r_overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      r_push_vld <= w_grp_done;
      if (w_grp_done) begin
        r_push <= w_entry;
      end
      if (w_pop) begin
        for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
          r_q[i] <= r_q[i+1];
        end
      end
      if (w_fifo_wr) begin
        r_q[w_wr_idx] <= r_push;
      end
      if (r_push_vld && !w_fifo_wr) begin
        r_overflow <= 1'b1;
      end
      r_cnt   <= w_cnt_nxt;
      r_wr_en <= (w_cnt_nxt != '0);
    end
  end

  assign wr.wr_en   = r_wr_en;
  assign wr.wr_addr = r_q[0].addr;
  assign wr.wr_data = r_q[0].data;
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_cam_frame_decimator.sv
// Directed bench for cam_frame_decimator; expected addresses follow CAM_MIRROR_EN when defined.
module tb_cam_frame_decimator;

  logic        clk = 1'b0;
  logic        resetn;
  logic        frame_start;
  logic        line_end;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic [4:0]  y_offset;
  logic        frame_done;
  logic        overflow;

  cam_frame_decimator_if u_if ();

  cam_frame_decimator u_dut (
    .clk         (clk),
    .resetn      (resetn),
    .frame_start (frame_start),
    .line_end    (line_end),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .y_offset    (y_offset),
    .wr          (u_if),
    .frame_done  (frame_done),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [30:0] q_wr [$];
  int          n_done = 0;
  int          wr_at_done = 0;

  // Write-port and frame_done observer.
  always @(posedge clk) begin
    if (resetn && u_if.wr_en && u_if.wr_ready) q_wr.push_back({u_if.wr_addr, u_if.wr_data});
    if (resetn && frame_done) begin
      n_done     = n_done + 1;
      wr_at_done = q_wr.size();
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic send_pix(input logic [15:0] d, input bit le);
    pix_valid = 1'b1;
    pix_data  = d;
    line_end  = le;
    tick(1);
    pix_valid = 1'b0;
    line_end  = 1'b0;
  endtask

  task automatic pulse_le();
    line_end = 1'b1;
    tick(1);
    line_end = 1'b0;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  function automatic int exp_addr(input int dy, input int dx, input int yoff);
    int y;
    int x;
`ifdef CAM_MIRROR_EN
    y = 119 - dy;
    x = 159 - dx;
`else
    y = dy;
    x = dx;
`endif
    y = y + yoff;
    if (y >= 120) y = y - 120;
    return y * 160 + x;
  endfunction

  initial begin
    int          base;
    int          err;
    int          k;
    int          done_base;
    logic [30:0] exp_e;

    resetn = 1'b0; frame_start = 1'b0; line_end = 1'b0; pix_valid = 1'b0;
    pix_data = '0; y_offset = '0; u_if.wr_ready = 1'b0;
    tick(3);
    chk("rst_wr_en", 32'(u_if.wr_en), 0);
    chk("rst_wr_addr", 32'(u_if.wr_addr), 0);
    chk("rst_wr_data", 32'(u_if.wr_data), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_overflow", 32'(overflow), 0);

    resetn = 1'b1; u_if.wr_ready = 1'b1;
    tick(2);
    for (int i = 0; i < 8; i++) send_pix(16'hFFFF, 1'b0);
    tick(4);
    chk("idle_ignore", q_wr.size(), 0);

    // One kept row of white pixels.
    pulse_fs();
    for (int i = 0; i < 640; i++) send_pix(16'hFFFF, i == 639);
    tick(10);
    chk("row_count", q_wr.size(), 160);
    err = 0;
    for (int i = 0; i < 160; i++) begin
      exp_e = {15'(exp_addr(0, i, 0)), 16'hFFFF};
      if (i < q_wr.size() && q_wr[i] !== exp_e) err++;
    end
    chk("row_content_errs", err, 0);
    chk("row_overflow", 32'(overflow), 0);

    // Averaging of one group and push latency.
    base = q_wr.size();
    pulse_fs();
    send_pix(16'h2000, 1'b0);
    send_pix(16'h4000, 1'b0);
    send_pix(16'h6000, 1'b0);
    send_pix(16'h8000, 1'b0);
    chk("lat_n1_wr_en", 32'(u_if.wr_en), 0);
    tick(1);
    chk("lat_n2_wr_en", 32'(u_if.wr_en), 1);
    chk("grp_addr", 32'(u_if.wr_addr), 32'(exp_addr(0, 0, 0)));
    chk("grp_data", 32'(u_if.wr_data), 32'h5000);
    tick(3);
    chk("grp_count", q_wr.size() - base, 1);
    chk("grp_no_done", n_done, 0);

    // Vertical offset wrap at source row 400.
    base = q_wr.size();
    y_offset = 5'd31;
    pulse_fs();
    repeat (400) pulse_le();
    for (int i = 0; i < 4; i++) send_pix(16'h001F, 1'b0);
    tick(5);
    chk("off_count", q_wr.size() - base, 1);
`ifdef CAM_MIRROR_EN
    chk("off_addr", 32'(q_wr[base][30:16]), 8159);
`else
    chk("off_addr", 32'(q_wr[base][30:16]), 1760);
`endif
    chk("off_data", 32'(q_wr[base][15:0]), 32'h001F);

    // Frame restart in the middle of a frame.
    base = q_wr.size();
    y_offset = 5'd0;
    pulse_fs();
    repeat (100) pulse_le();
    for (int i = 0; i < 4; i++) send_pix(16'h1111, 1'b0);
    tick(3);
    pulse_fs();
    for (int i = 0; i < 4; i++) send_pix(16'h2222, 1'b0);
    tick(5);
    chk("rs_count", q_wr.size() - base, 2);
`ifdef CAM_MIRROR_EN
    chk("rs_addr_row100", 32'(q_wr[base][30:16]), 15199);
    chk("rs_addr_restart", 32'(q_wr[base+1][30:16]), 19199);
`else
    chk("rs_addr_row100", 32'(q_wr[base][30:16]), 4000);
    chk("rs_addr_restart", 32'(q_wr[base+1][30:16]), 0);
`endif
    chk("rs_data", 32'(q_wr[base+1][15:0]), 32'h2222);
    chk("rs_no_done", n_done, 0);

    // Back-pressure: FIFO fills, later groups dropped.
    base = q_wr.size();
    pulse_fs();
    u_if.wr_ready = 1'b0;
    for (int i = 0; i < 40; i++) send_pix(16'h1234, 1'b0);
    tick(5);
    chk("st_wr_en", 32'(u_if.wr_en), 1);
    chk("st_addr", 32'(u_if.wr_addr), 32'(exp_addr(0, 0, 0)));
    chk("st_overflow", 32'(overflow), 1);
    tick(150);
    chk("st_addr_hold", 32'(u_if.wr_addr), 32'(exp_addr(0, 0, 0)));
    chk("st_data_hold", 32'(u_if.wr_data), 32'h1234);
    u_if.wr_ready = 1'b1;
    tick(10);
    chk("st_count", q_wr.size() - base, 4);
    chk("st_last_addr", 32'(q_wr[q_wr.size()-1][30:16]), 32'(exp_addr(0, 3, 0)));
    chk("st_overflow_sticky", 32'(overflow), 1);
    pulse_le();

    // Full frame, with a frame_start arriving during drain.
    base = q_wr.size();
    done_base = n_done;
    pulse_fs();
    for (int r = 0; r < 480; r++) begin
      if (r % 4 == 0) begin
        for (int c = 0; c < 640; c++) send_pix(16'h07E0, c == 639);
      end else begin
        pulse_le();
      end
    end
    pulse_fs();
    k = 0;
    while (n_done == done_base && k < 200) begin
      tick(1);
      k++;
    end
    tick(3);
    chk("ff_done_seen", 32'(n_done > done_base), 1);
    chk("ff_count", q_wr.size() - base, 19200);
    err = 0;
    for (int i = 0; i < 19200; i++) begin
      exp_e = {15'(exp_addr(i / 160, i % 160, 0)), 16'h07E0};
      if (base + i < q_wr.size() && q_wr[base+i] !== exp_e) err++;
    end
    chk("ff_content_errs", err, 0);
    chk("ff_last_addr", 32'(q_wr[base+19199][30:16]), 32'(exp_addr(119, 159, 0)));
    chk("ff_done_once", n_done - done_base, 1);
    chk("ff_done_after_last", wr_at_done - base, 19200);

    base = q_wr.size();
    for (int i = 0; i < 4; i++) send_pix(16'hFFFF, 1'b0);
    tick(5);
    chk("fs_latched_count", q_wr.size() - base, 1);
    chk("fs_latched_addr", 32'(q_wr[q_wr.size()-1][30:16]), 32'(exp_addr(0, 0, 0)));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
